// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int NREQ       = 2;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin pick between two requesters; combinational, one-hot winner.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            lg,
  output logic [NREQ-1:0] winner
);

  // lg names the requester granted last, so contention goes to the other one
  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = lg ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one access in flight, write in 1 cycle after IDLE,
// read data returned registered 3 cycles after the request is sampled.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  state_t          state, state_nxt;
  logic            lg;
  logic            op;
  logic [NREQ-1:0] win;
  logic [NREQ-1:0] pick;

  mem_arb_rr u_rr (
    .req    (req),
    .lg     (lg),
    .winner (pick)
  );

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    read      = 1'b0;
    write     = 1'b0;
    case (state)
      IDLE:   if (|req) state_nxt = ACCESS;
      ACCESS: begin
        gnt       = win;
        write     = op;
        read      = ~op;
        state_nxt = op ? IDLE : RDATA;
      end
      RDATA:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      lg      <= 1'b1;
      op      <= 1'b0;
      win     <= '0;
      addr    <= '0;
      data_in <= '0;
      rdata   <= '0;
      rvalid  <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= '0;
      if (state == IDLE && |req) begin
        win     <= pick;
        lg      <= pick[1];
        op      <= pick[1] ? we[1] : we[0];
        addr    <= pick[1] ? req_addr1 : req_addr0;
        data_in <= pick[1] ? req_wdata1 : req_wdata0;
      end
      // memory data became valid during RDATA; capture it on the way out
      if (state == RDATA) begin
        rdata  <= data_out;
        rvalid <= win;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-requester access request; bit i is requester i.
REQ-006 we  input  2  per-requester access type: 1 = write, 0 = read.
REQ-007 req_addr0, req_addr1  input  ADDR_W each  requester addresses.
REQ-008 req_wdata0, req_wdata1  input  DATA_W each  requester write data.
REQ-009 gnt  output  2  one-hot, one-cycle grant pulse; the access is being issued.
REQ-010 rvalid  output  2  one-hot, one-cycle pulse; read data valid for requester i.
REQ-011 rdata  output  DATA_W  registered read data, valid while any rvalid bit is 1.
REQ-012 read  output  1  memory read strobe.
REQ-013 write  output  1  memory write strobe.
REQ-014 addr  output  ADDR_W  memory address.
REQ-015 data_in  output  DATA_W  write data to the memory.
REQ-016 data_out  input (wire)  DATA_W  read data from the memory; valid the cycle after read is sampled.

Function
REQ-017 FSM states: IDLE, ACCESS, RDATA; at most one access outstanding.
REQ-018 IDLE: with req != 0, pick a winner; latch the winner's addr, wdata and we into the addr, data_in and op registers; go to ACCESS. With req == 0, stay in IDLE.
REQ-019 ACCESS (exactly one cycle): gnt[winner]=1; write=op, read=!op; addr and data_in hold the latched values. Next state is RDATA if op=read, else IDLE.
REQ-020 RDATA (exactly one cycle): read=0, write=0; on the exit edge, rdata <= data_out and rvalid[winner] <= 1 for the following cycle; next state IDLE.
REQ-021 Latency from req sampled in IDLE: write strobe plus gnt in the next cycle. For reads, rvalid and rdata arrive 3 cycles after the sampling edge.
REQ-022 Throughput: one write per 2 cycles; one read per 3 cycles.
REQ-023 Round-robin arbitration:
- last-grant register lg, updated when entering ACCESS.
- If both req bits are 1, grant !lg.
- If one req bit is 1, grant it regardless of lg.
REQ-024 A requester holds req, we, addr and wdata stable until it sees its gnt; it may drop or re-issue req in the cycle after gnt.
REQ-025 A req bit that is 1 in the cycle after its own gnt is a new request.
REQ-026 Inputs that change during ACCESS or RDATA have no effect on the in-flight access.
REQ-027 read and write are never both 1; gnt and rvalid are each at most one-hot.
REQ-028 rdata holds its last value when rvalid = 0.

Reset
REQ-029 rst_=0 immediately forces the following, independent of clk:
- state = IDLE, lg = 1 (requester 0 wins the first contention);
- gnt = 0, rvalid = 0, read = 0, write = 0;
- addr = 0, data_in = 0, rdata = 0.
REQ-030 Reset asserted during ACCESS or RDATA aborts the access; no rvalid is produced for it after rst_ deasserts.
REQ-031 The first arbitration happens on the first rising edge with rst_=1.

Structure
REQ-032 Package mem_arb_pkg holds:
- the state enum type (IDLE, ACCESS, RDATA);
- NREQ=2;
- default ADDR_W and DATA_W constants.
REQ-033 The round-robin pick logic is a sub-module, mem_arb_rr: inputs req and lg, output a one-hot winner; combinational.
REQ-034 All other logic is in mem_arbiter; no memory array inside the block.

Verification (bench drives a 32x8 memory model with a 1-cycle registered read)
REQ-035 Single write then read: requester 0 writes 8'hA5 to addr 5, then reads addr 5. Required: gnt[0] one cycle after each request; rvalid[0] with rdata=8'hA5 3 cycles after the read request.
REQ-036 Contention after reset: both requesters request in the same cycle (r0 writes addr 1 = 8'h11, r1 writes addr 2 = 8'h22). Required: gnt order r0 then r1; memory holds 8'h11 at 1 and 8'h22 at 2.
REQ-037 Sustained contention: both req held high for 8 grants. Required: gnt alternates 01,10,01,...; no requester is granted twice in a row.
REQ-038 Clear and pattern: clear all 32 addresses to 8'h00 and verify; then write data=address to all 32 and read back. Required: 0 mismatches; addr wraps cleanly at 31.
REQ-039 Reset mid-read: assert rst_ in the RDATA cycle of a read to addr 3. Required: all outputs 0 at once; no rvalid after release; the next request proceeds normally.
REQ-040 Mixed traffic: r0 reads addr 7 while r1 writes addr 7 = 8'h3C, simultaneously from reset. Required: r0 is served first and returns the old value; a later read of addr 7 returns 8'h3C.
